// File: rtl/pc_trace_buffer_if.sv
// Signal bundle between the CPU-side observer/reader and the PC trace buffer.
// rd_en requests a pop that is honoured only while empty=0; rd_valid then marks rd_data for exactly one cycle.
interface pc_trace_buffer_if #(
  parameter int PC_W  = 9,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             fetch;
  logic [PC_W-1:0]  pc;
  logic             halt;
  logic             clear;
  logic             watch_en;
  logic [PC_W-1:0]  watch_addr;
  logic             rd_en;
  logic [PC_W-1:0]  rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [CNT_W-1:0] fetch_cnt;
  logic             watch_hit;
  logic             watch_seen;
  logic             frozen;
  logic [1:0]       state_dbg;

  modport master (
    output fetch, pc, halt, clear, watch_en, watch_addr, rd_en,
    input  rd_data, rd_valid, empty, full, level, overflow, fetch_cnt,
           watch_hit, watch_seen, frozen, state_dbg
  );

  modport slave (
    input  fetch, pc, halt, clear, watch_en, watch_addr, rd_en,
    output rd_data, rd_valid, empty, full, level, overflow, fetch_cnt,
           watch_hit, watch_seen, frozen, state_dbg
  );
endinterface

// File: rtl/pc_trace_buffer.sv
// Instruction-fetch tracer: records the PC on every IF1 entry into a DEPTH-entry
// FIFO with fetch counter, PC watchpoint and freeze-on-halt for post-run inspection.
module pc_trace_buffer #(
  parameter int PC_W         = 9,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input logic               clk,
  input logic               reset,
  pc_trace_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FROZEN = 2'd2;

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic             fetch_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             watch_hit_q, watch_hit_d;
  logic             watch_seen_q, watch_seen_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PC_W-1:0]  rd_data_q, rd_data_d;

  logic fetch_evt, full, empty, pop, capture, grow;

  assign fetch_evt = bus.fetch & ~fetch_q;
  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  assign pop       = bus.rd_en & ~empty & ~bus.clear;
  assign capture   = fetch_evt & ~bus.halt & ~bus.clear & (state_q != S_FROZEN)
                   & ~(STOP_ON_FULL & full);
  // A capture into a full buffer only adds an entry if a pop frees a slot this cycle.
  assign grow      = capture & (~full | pop);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    cnt_d        = cnt_q;
    rd_valid_d   = pop;
    rd_data_d    = pop ? mem_q[rd_ptr_q] : rd_data_q;
    watch_hit_d  = capture & bus.watch_en & (bus.pc == bus.watch_addr);
    watch_seen_d = watch_seen_q | watch_hit_d;
    level_d      = level_q + {{(LVL_W-1){1'b0}}, grow} - {{(LVL_W-1){1'b0}}, pop};

    if (pop || (capture && full)) rd_ptr_d = rd_ptr_q + 1'b1;
    if (capture) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (full && !pop) overflow_d = 1'b1;
    end

    case (state_q)
      S_IDLE:   if (fetch_evt) state_d = bus.halt ? S_FROZEN : S_RUN;
      S_RUN:    if (bus.halt) state_d = S_FROZEN;
      default:  state_d = S_FROZEN;
    endcase
    if (STOP_ON_FULL && capture && (level_d == LVL_FULL)) state_d = S_FROZEN;

    // rd_data is deliberately left holding its last value across a clear.
    if (bus.clear) begin
      state_d      = S_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      overflow_d   = 1'b0;
      cnt_d        = '0;
      watch_hit_d  = 1'b0;
      watch_seen_d = 1'b0;
      rd_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
      watch_hit_q  <= 1'b0;
      watch_seen_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_q      <= bus.fetch;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      cnt_q        <= cnt_d;
      watch_hit_q  <= watch_hit_d;
      watch_seen_q <= watch_seen_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Storage needs no reset: entries are unreachable until written because level gates reads.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= bus.pc;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.level      = level_q;
  assign bus.overflow   = overflow_q;
  assign bus.fetch_cnt  = cnt_q;
  assign bus.watch_hit  = watch_hit_q;
  assign bus.watch_seen = watch_seen_q;
  assign bus.frozen     = (state_q == S_FROZEN);
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: three configurations driven in lockstep and checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_pc_trace_buffer;
  localparam int IDLE = 0, RUN = 1, FROZ = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch, halt, clear, watch_en, rd_en;
  logic [8:0] pc, watch_addr;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;
  int hits;

  always #5 clk = ~clk;

  // dut0: DEPTH 16 circular; dut1: DEPTH 4 circular, 3-bit counter; dut2: DEPTH 4 stop-on-full.
  pc_trace_buffer_if #(.PC_W(9), .DEPTH(16), .CNT_W(16)) if0 ();
  pc_trace_buffer_if #(.PC_W(9), .DEPTH(4),  .CNT_W(3))  if1 ();
  pc_trace_buffer_if #(.PC_W(9), .DEPTH(4),  .CNT_W(3))  if2 ();

  pc_trace_buffer #(.PC_W(9), .DEPTH(16), .CNT_W(16), .STOP_ON_FULL(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  pc_trace_buffer #(.PC_W(9), .DEPTH(4), .CNT_W(3), .STOP_ON_FULL(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  pc_trace_buffer #(.PC_W(9), .DEPTH(4), .CNT_W(3), .STOP_ON_FULL(1'b1))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.fetch = fetch;  assign if1.fetch = fetch;  assign if2.fetch = fetch;
  assign if0.pc = pc;        assign if1.pc = pc;        assign if2.pc = pc;
  assign if0.halt = halt;    assign if1.halt = halt;    assign if2.halt = halt;
  assign if0.clear = clear;  assign if1.clear = clear;  assign if2.clear = clear;
  assign if0.watch_en = watch_en;  assign if1.watch_en = watch_en;  assign if2.watch_en = watch_en;
  assign if0.watch_addr = watch_addr;  assign if1.watch_addr = watch_addr;  assign if2.watch_addr = watch_addr;
  assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;  assign if2.rd_en = rd_en;

  // ---------------- behavioural model ----------------
  logic [8:0] mq0[$], mq1[$], mq2[$];
  int         st[3];
  bit         ov[3], wh[3], ws[3], rv[3];
  int         cnt[3];
  logic [8:0] rdat[3];
  bit         fprev;

  function automatic int cfg_depth(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic int cfg_cmax(int k);
    return (k == 0) ? 65535 : 7;
  endfunction

  function automatic int model_size(int k);
    case (k)
      0:       return mq0.size();
      1:       return mq1.size();
      default: return mq2.size();
    endcase
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete(); mq2.delete();
    for (int k = 0; k < 3; k++) begin
      st[k] = IDLE; ov[k] = 0; wh[k] = 0; ws[k] = 0; rv[k] = 0; cnt[k] = 0; rdat[k] = '0;
    end
    fprev = 0;
  endtask

  task automatic model_step(int k);
    logic [8:0] q[$];
    logic [8:0] drop;
    int  depth;
    bit  stop, evt, popping, cap;
    case (k)
      0:       q = mq0;
      1:       q = mq1;
      default: q = mq2;
    endcase
    depth = cfg_depth(k);
    stop  = (k == 2);
    evt   = fetch && !fprev;
    if (clear) begin
      q.delete();
      st[k] = IDLE; ov[k] = 0; cnt[k] = 0; wh[k] = 0; ws[k] = 0; rv[k] = 0;
    end else begin
      popping = rd_en && (q.size() > 0);
      cap = evt && !halt && (st[k] != FROZ) && !(stop && q.size() == depth);
      rv[k] = popping;
      if (popping) rdat[k] = q.pop_front();
      if (cap) begin
        if (q.size() == depth) begin
          drop = q.pop_front();
          ov[k] = 1;
        end
        q.push_back(pc);
        if (cnt[k] < cfg_cmax(k)) cnt[k]++;
      end
      wh[k] = cap && watch_en && (pc == watch_addr);
      if (wh[k]) ws[k] = 1;
      if (st[k] == IDLE && evt) st[k] = halt ? FROZ : RUN;
      else if (st[k] == RUN && halt) st[k] = FROZ;
      if (stop && cap && q.size() == depth) st[k] = FROZ;
    end
    case (k)
      0:       mq0 = q;
      1:       mq1 = q;
      default: mq2 = q;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else begin
      for (int k = 0; k < 3; k++) model_step(k);
      fprev = fetch;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(int k, logic rv_a, logic [8:0] rd_a, logic em_a, logic fu_a,
                         logic [31:0] lv_a, logic ov_a, logic [31:0] fc_a,
                         logic wh_a, logic ws_a, logic fr_a);
    int sz;
    sz = model_size(k);
    check("rd_valid",   k, {31'b0, rv_a}, {31'b0, rv[k]});
    check("rd_data",    k, {23'b0, rd_a}, {23'b0, rdat[k]});
    check("empty",      k, {31'b0, em_a}, (sz == 0) ? 1 : 0);
    check("full",       k, {31'b0, fu_a}, (sz == cfg_depth(k)) ? 1 : 0);
    check("level",      k, lv_a, sz);
    check("overflow",   k, {31'b0, ov_a}, {31'b0, ov[k]});
    check("fetch_cnt",  k, fc_a, cnt[k]);
    check("watch_hit",  k, {31'b0, wh_a}, {31'b0, wh[k]});
    check("watch_seen", k, {31'b0, ws_a}, {31'b0, ws[k]});
    check("frozen",     k, {31'b0, fr_a}, (st[k] == FROZ) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp_dut(0, if0.rd_valid, if0.rd_data, if0.empty, if0.full, 32'(if0.level), if0.overflow,
              32'(if0.fetch_cnt), if0.watch_hit, if0.watch_seen, if0.frozen);
      cmp_dut(1, if1.rd_valid, if1.rd_data, if1.empty, if1.full, 32'(if1.level), if1.overflow,
              32'(if1.fetch_cnt), if1.watch_hit, if1.watch_seen, if1.frozen);
      cmp_dut(2, if2.rd_valid, if2.rd_data, if2.empty, if2.full, 32'(if2.level), if2.overflow,
              32'(if2.fetch_cnt), if2.watch_hit, if2.watch_seen, if2.frozen);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [8:0] p);
    fetch = 1'b1; pc = p; tick();
    fetch = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick();
    clear = 1'b0; tick();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_rd_data"},    0, 32'(if0.rd_data), 0);
    check({tag, "_rd_valid"},   0, 32'(if0.rd_valid), 0);
    check({tag, "_empty"},      0, 32'(if0.empty), 1);
    check({tag, "_full"},       0, 32'(if0.full), 0);
    check({tag, "_level"},      0, 32'(if0.level), 0);
    check({tag, "_overflow"},   0, 32'(if0.overflow), 0);
    check({tag, "_fetch_cnt"},  0, 32'(if0.fetch_cnt), 0);
    check({tag, "_watch_hit"},  0, 32'(if0.watch_hit), 0);
    check({tag, "_watch_seen"}, 0, 32'(if0.watch_seen), 0);
    check({tag, "_frozen"},     0, 32'(if0.frozen), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; fetch = 0; halt = 0; clear = 0; watch_en = 0; rd_en = 0;
    pc = '0; watch_addr = '0;
    model_reset();
    #1 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checking = 1'b1;
    tick();
    check_reset_values("reset");

    // In-order readout after a halted run.
    for (int p = 0; p < 4; p++) fetch_one(9'(p));
    halt = 1'b1; tick(); halt = 1'b0; tick();
    check("t1_fetch_cnt", 0, 32'(if0.fetch_cnt), 4);
    check("t1_frozen",    0, 32'(if0.frozen), 1);
    check("t1_level",     0, 32'(if0.level), 4);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_rd_valid", 0, 32'(if0.rd_valid), 1);
      check("t1_rd_data",  0, 32'(if0.rd_data), i);
    end
    rd_en = 1'b0; tick();
    check("t1_empty",    0, 32'(if0.empty), 1);
    check("t1_rd_valid_idle", 0, 32'(if0.rd_valid), 0);
    do_clear();

    // A held fetch level is a single event.
    fetch = 1'b1; pc = 9'd7;
    repeat (5) tick();
    fetch = 1'b0; tick();
    check("t2_level",     0, 32'(if0.level), 1);
    check("t2_fetch_cnt", 0, 32'(if0.fetch_cnt), 1);
    do_clear();

    // Fill past DEPTH=4 in circular and stop-on-full configurations.
    for (int p = 0; p < 6; p++) begin
      fetch_one(9'(p));
      if (p == 3) check("t4_frozen_at3", 2, 32'(if2.frozen), 1);
    end
    check("t3_level",     1, 32'(if1.level), 4);
    check("t3_overflow",  1, 32'(if1.overflow), 1);
    check("t4_overflow",  2, 32'(if2.overflow), 0);
    check("t4_fetch_cnt", 2, 32'(if2.fetch_cnt), 4);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_rd_data", 1, 32'(if1.rd_data), 2 + i);
      check("t4_rd_data", 2, 32'(if2.rd_data), i);
    end
    rd_en = 1'b0; tick();
    do_clear();

    // Capture and pop together on a full circular buffer.
    for (int p = 10; p < 14; p++) fetch_one(9'(p));
    check("t5_full", 1, 32'(if1.full), 1);
    fetch = 1'b1; pc = 9'd14; rd_en = 1'b1; tick();
    check("t5_rd_valid", 1, 32'(if1.rd_valid), 1);
    check("t5_rd_data",  1, 32'(if1.rd_data), 10);
    check("t5_level",    1, 32'(if1.level), 4);
    check("t5_overflow", 1, 32'(if1.overflow), 0);
    fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_rest", 1, 32'(if1.rd_data), 11 + i);
    end
    rd_en = 1'b0; tick();
    do_clear();

    // Watchpoint pulses, then asynchronous reset mid-run.
    watch_en = 1'b1; watch_addr = 9'd9; hits = 0;
    for (int i = 0; i < 3; i++) begin
      fetch = 1'b1; pc = (i == 0) ? 9'd8 : 9'd9; tick();
      hits += int'(if0.watch_hit);
      fetch = 1'b0; tick();
      hits += int'(if0.watch_hit);
    end
    check("t6_hits",       0, hits, 2);
    check("t6_watch_seen", 0, 32'(if0.watch_seen), 1);
    fetch_one(9'd3);
    reset = 1'b1;
    #1;
    check_reset_values("t6_async");
    tick();
    reset = 1'b0; watch_en = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      fetch      = 1'($urandom_range(0, 1));
      pc         = 9'($urandom_range(0, 15));
      halt       = ($urandom_range(0, 99) < 3);
      clear      = ($urandom_range(0, 99) < 4);
      rd_en      = ($urandom_range(0, 99) < 40);
      watch_en   = ($urandom_range(0, 99) < 70);
      if (n % 200 == 0) watch_addr = 9'($urandom_range(0, 15));
      reset      = ($urandom_range(0, 199) < 1);
      tick();
    end
    reset = 1'b0; fetch = 0; halt = 0; clear = 0; rd_en = 0;
    tick(); tick();
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
